mult_sequencer: RTL and testbench



---
 rtl/mult_sequencer.sv | 133 +++++++++++++
 tb/tb_mult_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: shift-and-add 32-bit unsigned multiplier controller that
// borrows the execute-stage ALU to compute the low word of op_a * op_b.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   start             - request, only sampled while idle
//   op_a, op_b        - multiplicand / multiplier, captured on accepted start
//   alu_result        - combinational result from the shared ALU
//   alu_op/a/b        - operation and operands driven to the shared ALU
//   alu_grant         - high while this block owns the ALU (ADD/SHIFT)
//   busy              - high in every state except IDLE
//   done              - one-cycle pulse, product valid
//   product           - registered result, held until the next accepted start
module mult_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] alu_result,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_grant,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_IDLE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] p;

    assign product = p;

    // Next-state decision. In SHIFT the decision looks at the multiplier as
    // it will be after this cycle's shift (Q[31:1] / Q[1]).
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (op_b == 32'd0)
                        nxt = DONE;
                    else if (op_b[0])
                        nxt = ADD;
                    else
                        nxt = SHIFT;
                end
            end
            ADD: nxt = SHIFT;
            SHIFT: begin
                if (q[31:1] == 31'd0)
                    nxt = DONE;
                else if (q[1])
                    nxt = ADD;
                else
                    nxt = SHIFT;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath and registered status outputs, decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            m         <= 32'd0;
            q         <= 32'd0;
            p         <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_grant <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m <= op_a;
                        q <= op_b;
                        p <= 32'd0;
                    end
                end
                ADD: p <= alu_result;
                SHIFT: begin
                    m <= alu_result;
                    q <= q >> 1;
                end
                DONE: ;
                default: ;
            endcase
            state     <= nxt;
            busy      <= (nxt != IDLE);
            done      <= (nxt == DONE);
            alu_grant <= (nxt == ADD) || (nxt == SHIFT);
        end
    end

    // ALU request mux; operands are zero whenever the ALU is not owned.
    always_comb begin
        alu_op = OP_IDLE;
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        unique case (state)
            ADD: begin
                alu_op = OP_ADD;
                alu_a  = p;
                alu_b  = m;
            end
            SHIFT: begin
                alu_op = OP_SLL;
                alu_a  = m;
                alu_b  = 32'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: randomized self-checking bench for mult_sequencer,
// with a behavioural ALU and an arithmetic product/timing reference.
module tb_mult_sequencer;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_IDLE = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_grant;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    mult_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_grant  (alu_grant),
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SLL:  alu_result = alu_a << alu_b[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_grant"}, 32'(alu_grant), 0);
        chk({tag, "_op"}, 32'(alu_op), 32'(OP_IDLE));
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
    endtask

    // One multiply. The expected ALU op sequence follows directly from the
    // multiplier bits: for each bit up to the highest set one, an ADD if the
    // bit is set, then a SHIFT. done follows in the next cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        logic [3:0]  seq[$];
        logic [31:0] mm;
        logic [31:0] pp;
        logic [31:0] prod;
        int          h;
        int          g;
        seq  = {};
        h    = -1;
        prod = a * b;
        for (int i = 0; i < 32; i++)
            if (b[i]) h = i;
        for (int i = 0; i <= h; i++) begin
            if (b[i]) seq.push_back(OP_ADD);
            seq.push_back(OP_SLL);
        end
        g = seq.size();
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        mm = a;
        pp = 32'd0;
        for (int c = 1; c <= g + 1; c++) begin
            if (c <= g) begin
                chk("op", 32'(alu_op), 32'(seq[c-1]));
                chk("grant", 32'(alu_grant), 1);
                chk("busy", 32'(busy), 1);
                chk("done_early", 32'(done), 0);
                if (seq[c-1] == OP_ADD) begin
                    chk("add_a", alu_a, pp);
                    chk("add_b", alu_b, mm);
                    pp = pp + mm;
                end else begin
                    chk("sll_a", alu_a, mm);
                    chk("sll_b", alu_b, 1);
                    mm = mm << 1;
                end
            end else begin
                chk("done", 32'(done), 1);
                chk("done_busy", 32'(busy), 1);
                chk("done_grant", 32'(alu_grant), 0);
                chk("done_op", 32'(alu_op), 32'(OP_IDLE));
                chk("done_a", alu_a, 0);
                chk("done_b", alu_b, 0);
                chk("product", product, prod);
            end
            @(posedge clk);
            #1;
        end
        chk_idle("after");
        chk("hold_product", product, prod);
    endtask

    // Start a long multiply, then reset asynchronously mid-operation.
    task automatic abort_run(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("abort");
        chk("abort_product", product, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_product", product, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'd3, 32'd5, 1'b0);
        run_op(32'h1234, 32'd0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        // start held high: ignored while busy and in DONE, re-accepted in IDLE
        run_op(32'd7, 32'd6, 1'b1);
        run_op(32'd7, 32'd6, 1'b0);

        abort_run(32'd9, 32'h80000000);
        run_op(32'd2, 32'd3, 1'b0);
        abort_run(32'd9, 32'h80000001);
        run_op(32'hDEADBEEF, 32'h00000101, 1'b0);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
